// File: rtl/pc_fetch_controller_pkg.sv
// pc_fetch_controller_pkg
// Shared definitions for the IF-stage fetch controller and its helpers:
// word width, reset PC / increment defaults, FSM state encoding, and a
// helper that word-aligns a byte address.
package pc_fetch_controller_pkg;

    localparam int          WORD_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INCR_DEFAULT     = 32'd4;

    // REQ   : request outstanding/issuable at pc
    // DRAIN : request at pc must complete before the redirect target is used
    // HOLD  : fetched instruction parked while IF/ID is stalled
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetchState_t;

    // Instruction fetches are word aligned; the low two bits are ignored.
    function automatic logic [WORD_W-1:0] alignWord(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_controller_if_hold_buf.sv
// if_hold_buf
// One-entry buffer for an {instr, pc, pcPlus4} triple. Used by the fetch
// controller to park an instruction that returned while IF/ID was stalled;
// equally usable by ID-stage stall logic.
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   load, clear           - capture inputs / drop contents (clear wins)
//   instrIn/pcIn/pcPlus4In - entry to capture
//   valid                 - buffer holds an entry
//   instr/pc/pcPlus4      - buffered entry
module if_hold_buf
    import pc_fetch_controller_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [WORD_W-1:0] instrIn,
    input  logic [WORD_W-1:0] pcIn,
    input  logic [WORD_W-1:0] pcPlus4In,
    output logic              valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pcPlus4
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            valid   <= 1'b0;
            instr   <= '0;
            pc      <= '0;
            pcPlus4 <= '0;
        end else if (load) begin
            valid   <= 1'b1;
            instr   <= instrIn;
            pc      <= pcIn;
            pcPlus4 <= pcPlus4In;
        end
    end

endmodule

// File: rtl/pc_fetch_controller.sv
// pc_fetch_controller
// IF-stage fetch sequencer. Owns the PC, feeds the external PC adder
// (adder_a = pc, adder_b = INCR, next PC taken from adder_sum), runs the
// instruction-memory request/ready handshake and loads the IF/ID register,
// honouring hazard stalls and branch/jump/exception redirects.
//
// Handshake: imem_req/imem_addr, once raised, are held stable until the
// cycle imem_ready=1 completes the transfer; imem_ready while imem_req=0 is
// ignored. Reset is the only thing allowed to drop an outstanding request.
//
// Ports:
//   clock, reset                 - clock, synchronous active-high reset
//   stall                        - hazard unit asks IF/ID to hold
//   redirect_valid, redirect_pc  - redirect this cycle and its target
//   adder_a, adder_b, adder_sum  - external PC adder operands and result
//   imem_req, imem_addr          - fetch request and address
//   imem_ready, imem_rdata       - memory completion and instruction
//   if_valid, if_instr, if_pc, if_pc_plus4 - IF/ID register
//   stateDbg                     - current FSM state (fetchState_t encoding)
module pc_fetch_controller
    import pc_fetch_controller_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [WORD_W-1:0] INCR     = INCR_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic [WORD_W-1:0] adder_a,
    output logic [WORD_W-1:0] adder_b,
    input  logic [WORD_W-1:0] adder_sum,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [WORD_W-1:0] if_instr,
    output logic [WORD_W-1:0] if_pc,
    output logic [WORD_W-1:0] if_pc_plus4,
    output logic [1:0]        stateDbg
);

    fetchState_t       state, stateNext;
    logic [WORD_W-1:0] pc, pcNext;
    logic [WORD_W-1:0] pendPc, pendPcNext;
    logic [WORD_W-1:0] redirTarget;
    logic              slotBusy;
    logic              ifLoadMem, ifLoadBuf, ifClear;
    logic              bufLoad, bufClear;
    logic              bufValid;
    logic [WORD_W-1:0] bufInstr, bufPc, bufPcPlus4;

    assign redirTarget = alignWord(redirect_pc);
    assign slotBusy    = stall & if_valid;

    assign adder_a   = pc;
    assign adder_b   = INCR;
    assign imem_addr = pc;
    // Request is dropped during reset so an in-flight fetch is abandoned.
    assign imem_req  = !reset && (state != HOLD);
    assign stateDbg  = state;

    if_hold_buf u_holdBuf (
        .clock     (clock),
        .reset     (reset),
        .load      (bufLoad),
        .clear     (bufClear),
        .instrIn   (imem_rdata),
        .pcIn      (pc),
        .pcPlus4In (adder_sum),
        .valid     (bufValid),
        .instr     (bufInstr),
        .pc        (bufPc),
        .pcPlus4   (bufPcPlus4)
    );

    always_comb begin
        stateNext  = state;
        pcNext     = pc;
        pendPcNext = pendPc;
        ifLoadMem  = 1'b0;
        ifLoadBuf  = 1'b0;
        ifClear    = 1'b0;
        bufLoad    = 1'b0;
        bufClear   = 1'b0;
        case (state)
            REQ: begin
                if (imem_ready) begin
                    if (redirect_valid) begin
                        pcNext  = redirTarget;
                        ifClear = 1'b1;
                    end else if (!slotBusy) begin
                        ifLoadMem = 1'b1;
                        pcNext    = adder_sum;
                    end else begin
                        bufLoad   = 1'b1;
                        pcNext    = adder_sum;
                        stateNext = HOLD;
                    end
                end else if (redirect_valid) begin
                    pendPcNext = redirTarget;
                    ifClear    = 1'b1;
                    stateNext  = DRAIN;
                end else if (!slotBusy) begin
                    ifClear = 1'b1;
                end
            end
            DRAIN: begin
                // Address stays on the outstanding request; the latest
                // redirect seen before completion is where fetch resumes.
                if (redirect_valid) begin
                    pendPcNext = redirTarget;
                    ifClear    = 1'b1;
                end else if (!slotBusy) begin
                    ifClear = 1'b1;
                end
                if (imem_ready) begin
                    pcNext    = redirect_valid ? redirTarget : pendPc;
                    stateNext = REQ;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    bufClear  = 1'b1;
                    ifClear   = 1'b1;
                    pcNext    = redirTarget;
                    stateNext = REQ;
                end else if (!slotBusy && bufValid) begin
                    ifLoadBuf = 1'b1;
                    bufClear  = 1'b1;
                    stateNext = REQ;
                end
            end
            default: stateNext = REQ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= REQ;
            pc          <= RESET_PC;
            pendPc      <= '0;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            if_pc_plus4 <= '0;
        end else begin
            state  <= stateNext;
            pc     <= pcNext;
            pendPc <= pendPcNext;
            if (ifClear) begin
                if_valid <= 1'b0;
            end else if (ifLoadMem) begin
                if_valid    <= 1'b1;
                if_instr    <= imem_rdata;
                if_pc       <= pc;
                if_pc_plus4 <= adder_sum;
            end else if (ifLoadBuf) begin
                if_valid    <= 1'b1;
                if_instr    <= bufInstr;
                if_pc       <= bufPc;
                if_pc_plus4 <= bufPcPlus4;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_controller.sv
module tb_pc_fetch_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] adder_a, adder_b, adder_sum;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc_plus4;
    logic [1:0]  stateDbg;

    int testCount = 0;
    int failCount = 0;

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    pc_fetch_controller dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .adder_a        (adder_a),
        .adder_b        (adder_b),
        .adder_sum      (adder_sum),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .stateDbg       (stateDbg)
    );

    // External PC adder and instruction memory contents.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return {addr[7:0], addr[31:8]} ^ 32'hC0DE_5A00;
    endfunction

    assign adder_sum  = adder_a + adder_b;
    assign imem_rdata = memWord(imem_addr);

    // ---------------- reference model ----------------
    // Fetch behaviour described as: the address being fetched, a list of
    // redirect targets waiting behind an in-flight request, and a queue of
    // instructions that came back while IF/ID could not accept them.
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcp4;
    } ifid_t;

    ifid_t       mIf;
    logic        mZero;       // IF/ID fields known to be the reset zeros
    logic [31:0] mPc;
    logic [95:0] exp_q[$];    // parked {instr, pc, pc+4}
    logic [31:0] tgtQ[$];     // redirect targets awaiting request completion

    task automatic modelStep(input logic s, input logic rv, input logic [31:0] rp,
                             input logic rd, input logic rs);
        logic [31:0] rt;
        logic        busy;
        logic [95:0] e;
        rt   = rp & 32'hFFFF_FFFC;
        busy = s && mIf.valid;
        if (rs) begin
            mPc = 32'h0;
            exp_q.delete();
            tgtQ.delete();
            mIf   = '0;
            mZero = 1'b1;
            return;
        end
        if (exp_q.size() != 0) begin
            if (rv) begin
                exp_q.delete();
                mPc       = rt;
                mIf.valid = 1'b0;
            end else if (!busy) begin
                e     = exp_q.pop_front();
                mIf   = {1'b1, e};
                mZero = 1'b0;
            end
        end else if (tgtQ.size() != 0) begin
            if (rv) begin
                tgtQ.push_back(rt);
                mIf.valid = 1'b0;
            end else if (!busy) begin
                mIf.valid = 1'b0;
            end
            if (rd) begin
                mPc = tgtQ[$];
                tgtQ.delete();
            end
        end else begin
            if (rd && rv) begin
                mPc       = rt;
                mIf.valid = 1'b0;
            end else if (rd && !busy) begin
                mIf   = {1'b1, memWord(mPc), mPc, mPc + 32'd4};
                mZero = 1'b0;
                mPc   = mPc + 32'd4;
            end else if (rd) begin
                exp_q.push_back({memWord(mPc), mPc, mPc + 32'd4});
                mPc = mPc + 32'd4;
            end else if (rv) begin
                tgtQ.push_back(rt);
                mIf.valid = 1'b0;
            end else if (!busy) begin
                mIf.valid = 1'b0;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Drive one cycle's inputs at the falling edge, check the DUT against
    // the model, advance the model, then move to the next falling edge.
    task automatic step(input logic s, input logic rv, input logic [31:0] rp,
                        input logic rd, input logic rs);
        logic [1:0] expState;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        imem_ready     = rd;
        reset          = rs;
        #1;
        expState = (exp_q.size() != 0) ? 2'd2 : (tgtQ.size() != 0) ? 2'd1 : 2'd0;
        checkVal("imem_req",  {31'b0, imem_req}, {31'b0, !rs && exp_q.size() == 0});
        checkVal("imem_addr", imem_addr, mPc);
        checkVal("adder_a",   adder_a, mPc);
        checkVal("adder_b",   adder_b, 32'd4);
        checkVal("state",     {30'b0, stateDbg}, {30'b0, expState});
        checkVal("if_valid",  {31'b0, if_valid}, {31'b0, mIf.valid});
        if (mIf.valid || mZero) begin
            checkVal("if_instr",    if_instr,    mIf.instr);
            checkVal("if_pc",       if_pc,       mIf.pc);
            checkVal("if_pc_plus4", if_pc_plus4, mIf.pcp4);
        end
        modelStep(s, rv, rp, rd, rs);
        @(posedge clock);
        @(negedge clock);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        rs, s, rv, rd;
        logic [31:0] rp;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ready     = 1'b0;
        reset          = 1'b1;
        modelStep(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (2) @(negedge clock);

        // Reset held, then zero-wait sequential fetch 0,4,8,12,...
        step(0, 0, 32'h0, 1, 1);
        step(0, 0, 32'h0, 1, 1);
        repeat (5) step(0, 0, 32'h0, 1, 0);

        // Redirect while the request completes: data dropped, bubble.
        step(0, 1, 32'h100, 1, 0);
        repeat (4) step(0, 0, 32'h0, 1, 0);

        // Slow memory with two redirects during the outstanding request.
        step(0, 1, 32'h200, 0, 0);
        step(0, 1, 32'h300, 0, 0);
        step(0, 0, 32'h0,   0, 0);
        step(0, 0, 32'h0,   1, 0);
        repeat (2) step(0, 0, 32'h0, 1, 0);

        // Stall while data returns: park it, ignore ready while idle, release.
        step(1, 0, 32'h0, 1, 0);
        step(1, 0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 1, 0);
        repeat (2) step(0, 0, 32'h0, 1, 0);

        // Address wrap at the top of memory.
        step(0, 1, 32'hFFFF_FFFC, 1, 0);
        repeat (3) step(0, 0, 32'h0, 1, 0);

        // Redirect to an unaligned target beats a stall on a live slot.
        step(1, 1, 32'h103, 1, 0);
        repeat (3) step(0, 0, 32'h0, 1, 0);

        // Reset while a request is outstanding; late ready then fetch.
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 1, 1);
        repeat (3) step(0, 0, 32'h0, 1, 0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 99) == 0);
            s  = ($urandom_range(0, 2) == 0);
            rv = ($urandom_range(0, 5) == 0);
            rd = ($urandom_range(0, 1) == 1);
            rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                             : $urandom;
            step(s, rv, rp, rd, rs);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
